// File: rtl/pc_stack_unit.sv
// pc_stack_unit: 12-bit program counter with a DEPTH-entry hardware return
// stack for CALL/RET. One op per cycle while pc_en is high, with one cycle of
// latency. A CALL on a full stack or a RET on an empty stack does not change
// the PC or the stack. Each of these cases sets a sticky error flag instead.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   pc_en             execute op this cycle (state holds when low)
//   op                00 NEXT, 01 JUMP, 10 CALL, 11 RET
//   jmp_addr          target for JUMP / CALL
//   err_clr           clears overflow/underflow (a same-edge set wins)
//   pc, pc_inc        current PC (registered) and pc+1 (combinational)
//   ret_addr          top-of-stack entry, 0 when empty
//   sp, full, empty   occupancy and its decodes
//   overflow          sticky flag: CALL issued while the stack was full
//   underflow         sticky flag: RET issued while the stack was empty
module pc_stack_unit #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter int          DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic [1:0]  op,
  input  logic [11:0] jmp_addr,
  input  logic        err_clr,
  output logic [11:0] pc,
  output logic [11:0] pc_inc,
  output logic [11:0] ret_addr,
  output logic [4:0]  sp,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        underflow
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_SP = 5'(DEPTH);

  typedef enum logic [1:0] {
    OP_NEXT = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  op_e opc;
  assign opc = op_e'(op);

  // Storage is plain registers with no reset; sp alone decides what is valid.
  logic [DEPTH-1:0][11:0] stk;
  logic [4:0]             sp_m1;

  logic do_call, do_ret, set_ovf, set_unf;

  assign pc_inc = pc + 12'd1;
  assign full   = (sp == DEPTH_SP);
  assign empty  = (sp == 5'd0);
  assign sp_m1  = sp - 5'd1;

  // Any index is a valid read when the stack is empty, but the result is masked to 0.
  assign ret_addr = empty ? 12'h000 : stk[sp_m1[AW-1:0]];

  assign do_call = pc_en && (opc == OP_CALL) && !full;
  assign do_ret  = pc_en && (opc == OP_RET)  && !empty;
  assign set_ovf = pc_en && (opc == OP_CALL) &&  full;
  assign set_unf = pc_en && (opc == OP_RET)  &&  empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      sp <= 5'd0;
    end else if (pc_en) begin
      unique case (opc)
        OP_NEXT: pc <= pc_inc;
        OP_JUMP: pc <= jmp_addr;
        OP_CALL: if (!full) begin
                   pc <= jmp_addr;
                   sp <= sp + 5'd1;
                 end
        OP_RET:  if (!empty) begin
                   pc <= ret_addr;
                   sp <= sp_m1;
                 end
        default: ;
      endcase
    end
  end

  // sp < DEPTH whenever a CALL is accepted, so the low bits address the slot exactly.
  always_ff @(posedge clk) begin
    if (do_call) stk[sp[AW-1:0]] <= pc_inc;
  end

  // Sticky flags: a set on the same edge takes priority over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= set_ovf | (overflow  & ~err_clr);
      underflow <= set_unf | (underflow & ~err_clr);
    end
  end

  logic unused_ok;
  assign unused_ok = do_ret;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios followed by random ops, all
// checked against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int          DEPTH    = 8;
  localparam logic [11:0] RESET_PC = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_en = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [11:0] jmp_addr = 12'h000;
  logic        err_clr = 1'b0;
  logic [11:0] pc, pc_inc, ret_addr;
  logic [4:0]  sp;
  logic        full, empty, overflow, underflow;

  pc_stack_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .op(op), .jmp_addr(jmp_addr),
    .err_clr(err_clr), .pc(pc), .pc_inc(pc_inc), .ret_addr(ret_addr),
    .sp(sp), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = int'(RESET_PC);
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic m_step(input bit en, input int o, input int a, input bit c);
    bit so = 0, su = 0;
    if (en) begin
      case (o)
        0: m_pc = (m_pc + 1) % 4096;
        1: m_pc = a;
        2: if (m_stk.size() < DEPTH) begin
             m_stk.push_back((m_pc + 1) % 4096);
             m_pc = a;
           end else so = 1;
        default: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                 else su = 1;
      endcase
    end
    m_ovf = so | (m_ovf & !c);
    m_unf = su | (m_unf & !c);
  endtask

  task automatic check_all(input string tag);
    int n = m_stk.size();
    chk({tag, ".pc"}, int'(pc), m_pc);
    chk({tag, ".pc_inc"}, int'(pc_inc), (m_pc + 1) % 4096);
    chk({tag, ".sp"}, int'(sp), n);
    chk({tag, ".ret_addr"}, int'(ret_addr), (n > 0) ? m_stk[n-1] : 0);
    chk({tag, ".full"}, int'(full), int'(n == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
  endtask

  task automatic do_op(input string tag, input bit en, input int o,
                       input int a, input bit c);
    pc_en = en; op = 2'(o); jmp_addr = 12'(a); err_clr = c;
    @(posedge clk);
    m_step(en, o, a, c);
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between edges; outputs checked before any edge arrives.
  task automatic async_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    m_reset();
    rst = 1'b1;
    #2;
    check_all("reset");
    #1 rst = 1'b0;

    // three NEXTs from reset
    do_op("nx1", 1, 0, 0, 0);
    do_op("nx2", 1, 0, 0, 0);
    do_op("nx3", 1, 0, 0, 0);
    chk("nx3.const", int'(pc), 12'h003);

    // wrap through FFF
    do_op("jfe", 1, 1, 12'hFFE, 0);
    do_op("wr1", 1, 0, 0, 0);
    do_op("wr2", 1, 0, 0, 0);
    chk("wrap.const", int'(pc), 12'h000);

    // call / next / return
    do_op("j10", 1, 1, 12'h010, 0);
    do_op("call", 1, 2, 12'h200, 0);
    chk("call.ret_const", int'(ret_addr), 12'h011);
    do_op("cnx", 1, 0, 0, 0);
    do_op("ret", 1, 3, 0, 0);
    chk("ret.const", int'(pc), 12'h011);

    // fill to DEPTH, then overflow
    do_op("j0", 1, 1, 12'h000, 0);
    for (int i = 0; i < DEPTH + 1; i++) do_op($sformatf("fill%0d", i), 1, 2, 12'h100, 0);
    chk("ovf.const", int'(overflow), 1);
    // disabled cycle: state holds but err_clr still acts
    do_op("hold_clr", 0, 3, 0, 1);

    // underflow, then clear racing a new underflow
    async_rst("rst_mid");
    do_op("unf", 1, 3, 0, 0);
    do_op("unf_clr", 1, 3, 0, 1);
    chk("unf_clr.const", int'(underflow), 1);
    do_op("clr", 1, 0, 0, 1);

    // reset between CALL and RET discards the stack
    do_op("c1", 1, 2, 12'h300, 0);
    do_op("c2", 1, 2, 12'h340, 0);
    async_rst("rst_calls");
    do_op("ret_after_rst", 1, 3, 0, 0);

    // random traffic, RET/CALL biased so the stack visits both bounds
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      int o = (r < 15) ? 0 : (r < 25) ? 1 : (r < 62) ? 2 : 3;
      if ($urandom_range(0, 199) == 0) async_rst("rnd_rst");
      do_op("rnd", $urandom_range(0, 9) != 0, o, int'($urandom_range(0, 4095)),
            $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 12'h000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of return-stack entries (power of two, 2..16).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port pc_en  input  1  when high, op is executed this cycle; when low, all state holds.
REQ-006 The block SHALL have port op  input  2  operation: 00 NEXT, 01 JUMP, 10 CALL, 11 RET.
REQ-007 The block SHALL have port jmp_addr  input  12  target address for JUMP and CALL.
REQ-008 The block SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-009 The block SHALL have port pc  output  12  current program counter, registered.
REQ-010 The block SHALL have port pc_inc  output  12  combinational pc+1, modulo 4096.
REQ-011 The block SHALL have port ret_addr  output  12  top-of-stack entry; 12'h000 when the stack is empty.
REQ-012 The block SHALL have port sp  output  5  number of occupied entries, 0..DEPTH.
REQ-013 The block SHALL have ports full and empty  output  1 each  sp==DEPTH and sp==0 respectively, combinational from sp.
REQ-014 The block SHALL have ports overflow and underflow  output  1 each  sticky error flags.

Function
REQ-015 NEXT with pc_en SHALL load pc <= pc_inc on the next edge; 12'hFFF wraps to 12'h000, no flag.
REQ-016 JUMP with pc_en SHALL load pc <= jmp_addr; the stack is unchanged.
REQ-017 CALL with pc_en and not full SHALL write pc_inc at stack[sp], increment sp, and load pc <= jmp_addr, all in the same edge.
REQ-018 CALL with pc_en and full SHALL leave pc, sp and stack unchanged and set overflow.
REQ-019 RET with pc_en and not empty SHALL load pc <= ret_addr and decrement sp in the same edge.
REQ-020 RET with pc_en and empty SHALL leave pc and sp unchanged and set underflow.
REQ-021 Latency SHALL be one cycle: the op sampled at edge N is visible on pc, sp, full, empty and ret_addr after edge N.
REQ-022 Back-to-back ops SHALL be supported every cycle with no bubbles, including CALL immediately followed by RET, which returns to the address after the CALL.
REQ-023 With pc_en low, pc, sp, stack contents and flags SHALL hold, except that err_clr still acts.
REQ-024 err_clr SHALL clear overflow and underflow on the next edge; if a new error occurs on the same edge, that flag SHALL be set, because set wins over clear.
REQ-025 Stack storage SHALL be registers with no reset; only entries below sp are observable via ret_addr.
REQ-026 ret_addr SHALL equal stack[sp-1] combinationally when sp>0.
REQ-027 The stack pointer SHALL never exceed DEPTH or go below 0 under any input sequence.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for a clock edge, force pc=RESET_PC, sp=0, overflow=0 and underflow=0; as a result empty=1, full=0 and ret_addr=12'h000.
REQ-029 Reset asserted mid-sequence, for example between a CALL and a RET, SHALL discard the stack; a following RET SHALL flag underflow.
REQ-030 On the first rising edge after rst deasserts, the block SHALL execute the sampled op normally.

Verification
REQ-031 Reset, then 3x NEXT -> pc 000,001,002,003; sp=0; empty=1.
REQ-032 JUMP 0xFFE, then 2x NEXT -> pc FFE, FFF, 000; no flag set.
REQ-033 At pc=0x010, CALL 0x200, NEXT, then RET -> pc 200, 201, 011; sp 1, 1, 0; ret_addr 011 while sp=1.
REQ-034 Starting from DEPTH=8, pc=0x000, 9x CALL 0x100 -> the first eight CALLs push 001,101,...,101 (first entry 001, the remaining seven 101), sp=8, full=1; the ninth CALL leaves pc=100 and sp=8 and sets overflow; err_clr then clears overflow.
REQ-035 RET with empty stack -> pc unchanged, underflow=1; err_clr and a RET underflow on the same edge -> underflow stays 1.
REQ-036 After CALL twice, assert rst between edges -> pc=RESET_PC, sp=0 asynchronously; a following RET sets underflow.
